// File: rtl/priority_irq_controller.sv
// Priority interrupt front end: captures request edges into a pending register and
// presents the highest enabled pending line as an ID through a valid/ack handshake.
module priority_irq_controller #(
    parameter int N  = 8,
    parameter int IW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  irq,
    input  logic [N-1:0]  mask,
    input  logic          ack,
    output logic          irq_valid,
    output logic [IW-1:0] irq_id,
    output logic [N-1:0]  pending,
    output logic [N-1:0]  overrun
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        GAP
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [N-1:0]  irq_prev;
    logic [N-1:0]  irq_edge;
    logic [N-1:0]  req;
    logic [N-1:0]  clr;
    logic [IW-1:0] sel;
    logic [IW-1:0] id_next;
    logic          valid_next;
    logic          accept;

    assign irq_edge = irq & ~irq_prev;
    assign req      = pending & mask;
    assign accept   = (state == BUSY) && ack;

    // Later iterations overwrite earlier ones, so the highest requesting index wins.
    always_comb begin
        sel = '0;
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                sel = IW'(i);
            end
        end
    end

    always_comb begin
        clr = '0;
        if (accept) begin
            clr[irq_id] = 1'b1;
        end
    end

    // Edge capture; the set term is OR-ed last so a same-cycle edge beats the clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_prev <= '0;
            pending  <= '0;
            overrun  <= '0;
        end else begin
            irq_prev <= irq;
            pending  <= (pending & ~clr) | irq_edge;
            overrun  <= overrun | (irq_edge & pending & ~clr);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            irq_valid <= 1'b0;
            irq_id    <= '0;
        end else begin
            state     <= state_next;
            irq_valid <= valid_next;
            irq_id    <= id_next;
        end
    end

    // GAP exists so the cleared pending bit is registered before the next selection.
    always_comb begin
        state_next = state;
        valid_next = irq_valid;
        id_next    = irq_id;
        case (state)
            IDLE: begin
                if (|req) begin
                    id_next    = sel;
                    valid_next = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (ack) begin
                    valid_next = 1'b0;
                    state_next = GAP;
                end
            end
            GAP: begin
                state_next = IDLE;
            end
            default: begin
                valid_next = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_priority_irq_controller.sv
// Bench for priority_irq_controller: directed scenarios plus a randomized run
// compared against a cycle-level behavioural model.
`timescale 1ns/1ps
module tb_priority_irq_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] irq;
    logic [7:0] mask;
    logic       ack;
    logic       irq_valid;
    logic [2:0] irq_id;
    logic [7:0] pending;
    logic [7:0] overrun;

    int errors = 0;
    int checks = 0;

    logic [7:0] m_prev, m_pend, m_ovr;
    logic       m_valid;
    logic [2:0] m_id;
    int         m_cool;

    priority_irq_controller #(.N(8), .IW(3)) dut (
        .clk(clk), .rst(rst), .irq(irq), .mask(mask), .ack(ack),
        .irq_valid(irq_valid), .irq_id(irq_id), .pending(pending), .overrun(overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #10_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic int msb(input int v);
        int n;
        n = 0;
        while (v > 1) begin
            v = v / 2;
            n++;
        end
        return n;
    endfunction

    // One clock edge: model follows the rules using inputs as sampled at the edge.
    task automatic tick();
        logic [7:0] s_irq, s_mask, e, c;
        logic       s_ack, s_rst;
        s_irq = irq; s_mask = mask; s_ack = ack; s_rst = rst;
        @(posedge clk);
        if (s_rst) begin
            m_prev = 0; m_pend = 0; m_ovr = 0; m_valid = 0; m_id = 0; m_cool = 0;
        end else begin
            e = s_irq & ~m_prev;
            c = (m_valid && s_ack) ? (8'd1 << m_id) : 8'd0;
            m_ovr  = m_ovr | (e & m_pend & ~c);
            m_prev = s_irq;
            if (m_valid) begin
                if (s_ack) begin
                    m_valid = 0;
                    m_cool  = 1;
                end
            end else if (m_cool > 0) begin
                m_cool--;
            end else if ((m_pend & s_mask) != 0) begin
                m_valid = 1;
                m_id    = 3'(msb(int'(m_pend & s_mask)));
            end
            m_pend = (m_pend & ~c) | e;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1; ack = 0; irq = 0; mask = 8'hFF;
        tick();
        rst = 0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1; irq = 0; mask = 8'hFF; ack = 0;
        tick(); tick();
        checks++; if (irq_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_valid got=%b exp=0", irq_valid); end
        checks++; if (irq_id !== 3'd0) begin errors++; $display("[TB] FAIL rst_id got=%0d exp=0", irq_id); end
        checks++; if (pending !== 8'h00) begin errors++; $display("[TB] FAIL rst_pend got=%h exp=00", pending); end
        checks++; if (overrun !== 8'h00) begin errors++; $display("[TB] FAIL rst_ovr got=%h exp=00", overrun); end
        rst = 0;
        tick();
        checks++; if (pending !== 8'h00 || irq_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_release got pend=%h valid=%b exp pend=00 valid=0", pending, irq_valid); end
    endtask

    task automatic test_basic();
        irq = 8'h2A;
        tick();
        checks++; if (pending !== 8'h2A || irq_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_capture got pend=%h valid=%b exp pend=2a valid=0", pending, irq_valid); end
        tick();
        checks++; if (irq_valid !== 1'b1 || irq_id !== 3'd5) begin errors++; $display("[TB] FAIL basic_first got valid=%b id=%0d exp valid=1 id=5", irq_valid, irq_id); end
        ack = 1; tick(); ack = 0;
        checks++; if (irq_valid !== 1'b0 || pending !== 8'h0A) begin errors++; $display("[TB] FAIL basic_ack5 got valid=%b pend=%h exp valid=0 pend=0a", irq_valid, pending); end
        tick();
        checks++; if (irq_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_gap got valid=%b exp=0", irq_valid); end
        tick();
        checks++; if (irq_valid !== 1'b1 || irq_id !== 3'd3) begin errors++; $display("[TB] FAIL basic_second got valid=%b id=%0d exp valid=1 id=3", irq_valid, irq_id); end
        ack = 1; tick(); ack = 0;
        tick(); tick();
        checks++; if (irq_valid !== 1'b1 || irq_id !== 3'd1) begin errors++; $display("[TB] FAIL basic_third got valid=%b id=%0d exp valid=1 id=1", irq_valid, irq_id); end
        ack = 1; tick(); ack = 0;
        checks++; if (pending !== 8'h00) begin errors++; $display("[TB] FAIL basic_empty got pend=%h exp=00", pending); end
        tick(); tick(); tick();
        checks++; if (irq_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_idle got valid=%b exp=0", irq_valid); end
        irq = 0; tick();
    endtask

    task automatic test_mask();
        mask = 8'h0F; irq = 8'h84;
        tick(); tick();
        checks++; if (irq_valid !== 1'b1 || irq_id !== 3'd2) begin errors++; $display("[TB] FAIL mask_low got valid=%b id=%0d exp valid=1 id=2", irq_valid, irq_id); end
        ack = 1; tick(); ack = 0;
        tick(); tick(); tick();
        checks++; if (irq_valid !== 1'b0 || pending !== 8'h80) begin errors++; $display("[TB] FAIL mask_blocked got valid=%b pend=%h exp valid=0 pend=80", irq_valid, pending); end
        mask = 8'hFF; tick();
        checks++; if (irq_valid !== 1'b1 || irq_id !== 3'd7) begin errors++; $display("[TB] FAIL mask_unmask got valid=%b id=%0d exp valid=1 id=7", irq_valid, irq_id); end
        ack = 1; tick(); ack = 0;
        tick(); irq = 0; tick();
    endtask

    task automatic test_hold();
        irq = 8'h02; tick(); tick();
        checks++; if (irq_valid !== 1'b1 || irq_id !== 3'd1) begin errors++; $display("[TB] FAIL hold_start got valid=%b id=%0d exp valid=1 id=1", irq_valid, irq_id); end
        irq = 8'h42; tick(); tick();
        checks++; if (irq_valid !== 1'b1 || irq_id !== 3'd1 || pending !== 8'h42) begin errors++; $display("[TB] FAIL hold_higher got valid=%b id=%0d pend=%h exp valid=1 id=1 pend=42", irq_valid, irq_id, pending); end
        mask = 8'h00; tick();
        checks++; if (irq_valid !== 1'b1 || irq_id !== 3'd1) begin errors++; $display("[TB] FAIL hold_masked got valid=%b id=%0d exp valid=1 id=1", irq_valid, irq_id); end
        mask = 8'hFF;
        ack = 1; tick(); ack = 0;
        tick(); tick();
        checks++; if (irq_valid !== 1'b1 || irq_id !== 3'd6) begin errors++; $display("[TB] FAIL hold_next got valid=%b id=%0d exp valid=1 id=6", irq_valid, irq_id); end
        ack = 1; tick(); ack = 0;
        tick(); irq = 0; tick();
    endtask

    task automatic test_overrun();
        irq = 8'h10; tick(); tick();
        irq = 8'h00; tick();
        irq = 8'h10; ack = 1; tick(); ack = 0;
        checks++; if (pending !== 8'h10 || overrun !== 8'h00 || irq_valid !== 1'b0) begin errors++; $display("[TB] FAIL ovr_setwins got pend=%h ovr=%h valid=%b exp pend=10 ovr=00 valid=0", pending, overrun, irq_valid); end
        tick(); tick();
        checks++; if (irq_valid !== 1'b1 || irq_id !== 3'd4) begin errors++; $display("[TB] FAIL ovr_represent got valid=%b id=%0d exp valid=1 id=4", irq_valid, irq_id); end
        irq = 8'h00; tick();
        irq = 8'h10; tick();
        checks++; if (overrun !== 8'h10 || pending !== 8'h10) begin errors++; $display("[TB] FAIL ovr_flag got ovr=%h pend=%h exp ovr=10 pend=10", overrun, pending); end
        ack = 1; tick(); ack = 0;
        irq = 0; tick(); tick();
        checks++; if (overrun !== 8'h10 || pending !== 8'h00) begin errors++; $display("[TB] FAIL ovr_sticky got ovr=%h pend=%h exp ovr=10 pend=00", overrun, pending); end
    endtask

    task automatic test_ack_idle();
        do_reset();
        mask = 8'hFE; irq = 8'h01;
        tick(); tick(); tick();
        checks++; if (pending !== 8'h01 || irq_valid !== 1'b0) begin errors++; $display("[TB] FAIL ackidle_pend got pend=%h valid=%b exp pend=01 valid=0", pending, irq_valid); end
        ack = 1; tick(); tick(); ack = 0;
        checks++; if (pending !== 8'h01 || overrun !== 8'h00) begin errors++; $display("[TB] FAIL ackidle_ignored got pend=%h ovr=%h exp pend=01 ovr=00", pending, overrun); end
        irq = 0; mask = 8'hFF; tick();
        checks++; if (irq_valid !== 1'b1 || irq_id !== 3'd0) begin errors++; $display("[TB] FAIL ackidle_unmask got valid=%b id=%0d exp valid=1 id=0", irq_valid, irq_id); end
        ack = 1; tick(); ack = 0; tick();
    endtask

    task automatic test_reset_busy();
        do_reset();
        irq = 8'hFF; tick(); tick();
        checks++; if (irq_valid !== 1'b1 || irq_id !== 3'd7 || pending !== 8'hFF) begin errors++; $display("[TB] FAIL rstbusy_pre got valid=%b id=%0d pend=%h exp valid=1 id=7 pend=ff", irq_valid, irq_id, pending); end
        rst = 1; tick();
        checks++; if (irq_valid !== 1'b0 || pending !== 8'h00 || overrun !== 8'h00) begin errors++; $display("[TB] FAIL rstbusy_clear got valid=%b pend=%h ovr=%h exp valid=0 pend=00 ovr=00", irq_valid, pending, overrun); end
        rst = 0; tick();
        checks++; if (pending !== 8'hFF || irq_valid !== 1'b0) begin errors++; $display("[TB] FAIL rstbusy_release got pend=%h valid=%b exp pend=ff valid=0", pending, irq_valid); end
        tick();
        checks++; if (irq_valid !== 1'b1 || irq_id !== 3'd7) begin errors++; $display("[TB] FAIL rstbusy_present got valid=%b id=%0d exp valid=1 id=7", irq_valid, irq_id); end
        do_reset();
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            irq = irq ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            if ($urandom_range(0, 15) == 0) mask = 8'($urandom) | 8'($urandom);
            ack = ($urandom_range(0, 2) == 0);
            rst = ($urandom_range(0, 249) == 0);
            tick();
            checks++; if (irq_valid !== m_valid) begin errors++; $display("[TB] FAIL rand_valid cycle=%0d got=%b exp=%b", n, irq_valid, m_valid); end
            if (m_valid) begin
                checks++; if (irq_id !== m_id) begin errors++; $display("[TB] FAIL rand_id cycle=%0d got=%0d exp=%0d", n, irq_id, m_id); end
            end
            checks++; if (pending !== m_pend) begin errors++; $display("[TB] FAIL rand_pend cycle=%0d got=%h exp=%h", n, pending, m_pend); end
            checks++; if (overrun !== m_ovr) begin errors++; $display("[TB] FAIL rand_ovr cycle=%0d got=%h exp=%h", n, overrun, m_ovr); end
        end
        rst = 0; ack = 0;
    endtask

    initial begin
        rst = 1; irq = 0; mask = 8'hFF; ack = 0;
        m_prev = 0; m_pend = 0; m_ovr = 0; m_valid = 0; m_id = 0; m_cool = 0;
        $display("[TB] starting");
        test_reset();
        test_basic();
        test_mask();
        test_hold();
        test_overrun();
        test_ack_idle();
        test_reset_busy();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/priority_irq_controller.md
Name: priority_irq_controller

Overview:
- Sequential front end for the 8-to-3 priority encoder stage.
- Captures rising edges on 8 interrupt request lines into a pending register and applies an enable mask.
- Presents the highest-priority enabled pending request as a 3-bit ID, bit 7 highest (bit 7 -> 3'b111, bit 0 -> 3'b000), through a valid/ack handshake.
- Clears the serviced pending bit on ack and flags lost events.

Parameters:
- N, 8, number of request lines; fixed at 8 for this revision.
- IW, 3, ID width; must satisfy N <= 2**IW.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- irq  input  N  request lines, already synchronous to clk; an event is a 0->1 transition between consecutive samples.
- mask  input  N  enable per line (1 = may be presented); does not gate capture.
- ack  input  1  consumer accepts the presented ID; meaningful only while irq_valid=1.
- irq_valid  output  1  irq_id holds a valid request.
- irq_id  output  IW  index of the presented request.
- pending  output  N  current pending register.
- overrun  output  N  sticky per-line flag: event arrived while that bit was already pending.

Behaviour:
- Reset (rst=1 at a clock edge):
  - irq_valid=0, irq_id=0, pending=0, overrun=0, irq_prev=0, state=IDLE.
  - Because irq_prev resets to 0, a line held high through reset release registers one event at the first sampled edge.
- Edge detect:
  - edge = irq & ~irq_prev.
  - irq_prev <= irq every cycle.
- Pending update: pending <= (pending & ~clr) | edge.
  - clr is a one-hot of irq_id, only in the cycle ack is accepted.
  - Set wins: an edge and a clear on the same bit in the same cycle leaves the bit set.
- Overrun: overrun[i] <= overrun[i] | (edge[i] & pending[i] & ~clr[i]). Cleared only by rst.
- Priority select: sel = highest index i with pending[i] & mask[i]. It is computed from registered pending, so a new edge is visible one cycle after capture.
- State machine:
  - IDLE: if (pending & mask) != 0, load irq_id <= sel, irq_valid <= 1, go to BUSY. Otherwise stay.
  - BUSY: irq_id and irq_valid are held stable regardless of irq, mask or new higher-priority edges. On ack=1: irq_valid <= 0, clear pending[irq_id], go to GAP.
  - GAP: one recovery cycle so the cleared pending value is seen; go to IDLE unconditionally.
- Latency:
  - Event sampled at edge k -> pending bit set after k -> irq_valid=1 after edge k+1 (if idle and unmasked).
  - Ack sampled at edge m -> irq_valid=0 after m -> earliest next irq_valid=1 after edge m+2.
- ack while irq_valid=0 is ignored; it has no effect on pending.
- irq_id keeps its last value while irq_valid=0; it is only meaningful with valid.
- A masked pending bit stays pending indefinitely and is presented once unmasked.
- Masking the presented bit during BUSY does not withdraw it.
- Reset mid-handshake (rst during BUSY or GAP): all state clears immediately, the outstanding request is dropped, and no ack is required.
- All outputs are registered. There are no combinational paths from inputs to outputs.

Test Plan:
1. Reset, then irq 0x00 -> 0x2A held -> pending=0x2A one cycle later; irq_valid=1 with irq_id=3'b101 the next cycle. Ack -> bit 5 cleared (pending=0x0A); two cycles later irq_id=3'b011; ack -> then 3'b001; ack -> pending=0x00, irq_valid stays 0.
2. mask=0x0F, events on lines 7 and 2 -> irq_id=3'b010 first. After ack, no further valid while pending=0x80. Set mask=0xFF -> irq_id=3'b111.
3. While BUSY with irq_id=3'b001, raise line 6 -> irq_id stays 3'b001 until ack; after GAP, irq_id=3'b110.
4. Line 4 pending and not acked; pulse line 4 again (0->1) -> overrun=0x10, pending stays 0x10. Edge on line 4 in the same cycle as ack of ID 4 -> pending[4] remains 1 and overrun stays 0 for that event.
5. ack pulsed with irq_valid=0 and pending=0x01 masked off -> pending unchanged at 0x01, overrun=0x00.
6. rst asserted while BUSY with pending=0xFF -> next cycle irq_valid=0, pending=0x00, overrun=0x00. irq held at 0xFF through reset release -> pending=0xFF one cycle after release.
